// File: rtl/whac_pkg.sv
// Shared definitions for the score path: BCD digit type, FSM state
// encoding and the double-dabble nibble adjust.
package whac_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } conv_state_t;

  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

  // A nibble >= 5 would carry into the next decade after the shift, so pre-add 3.
  function automatic bcd_digit_t bcd_adjust(input bcd_digit_t d);
    return (d >= BCD_ADJ_THRESH) ? bcd_digit_t'(d + BCD_ADJ_ADD) : d;
  endfunction

endpackage

// File: rtl/bcd_shift_step.sv
// One double-dabble iteration: adjust every BCD nibble, then shift the
// whole {BCD, binary} register left by one bit.
module bcd_shift_step
  import whac_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic [4*DIGITS+BIN_W-1:0] i_sr,
  output logic [4*DIGITS+BIN_W-1:0] o_sr
);

  localparam int SR_W = 4*DIGITS + BIN_W;

  logic [SR_W-1:0] w_adj;

  always_comb begin
    w_adj = i_sr;
    for (int d = 0; d < DIGITS; d++) begin
      w_adj[BIN_W+4*d +: 4] = bcd_adjust(i_sr[BIN_W+4*d +: 4]);
    end
    o_sr = {w_adj[SR_W-2:0], 1'b0};
  end

endmodule

// File: rtl/score_bcd_converter.sv
// Watches the binary score bus and, on each change, runs an iterative
// double-dabble conversion to packed BCD for the display drivers.
module score_bcd_converter
  import whac_pkg::*;
#(
  parameter int MAX_SCORE = 9999,
  parameter int DIGITS    = 4,
  localparam int BIN_W    = $clog2(MAX_SCORE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      score_count,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;

  localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(MAX_SCORE);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  function automatic logic [BIN_W-1:0] sat_score(input logic [BIN_W-1:0] v);
    return (v > MAX_BIN) ? MAX_BIN : v;
  endfunction

  conv_state_t        r_state;
  logic [SR_W-1:0]    r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_last;
  logic [BIN_W-1:0]   r_capt;
  logic               r_ovf_pend;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_valid;
  logic               r_busy;
  logic               r_ovf;
  logic [SR_W-1:0]    w_sr_next;

  bcd_shift_step #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_step (
    .i_sr (r_sr),
    .o_sr (w_sr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_last     <= '0;
      r_capt     <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (score_count != r_last) begin
            r_sr       <= {{BCD_W{1'b0}}, sat_score(score_count)};
            r_ovf_pend <= (score_count > MAX_BIN);
            r_capt     <= score_count;
            r_cnt      <= '0;
            r_state    <= ST_CONVERT;
            r_busy     <= 1'b1;
          end
        end
        ST_CONVERT: begin
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) r_state <= ST_DONE;
        end
        ST_DONE: begin
          // Remember the raw sample so an out-of-range input is not re-triggered.
          r_bcd   <= r_sr[SR_W-1 -: BCD_W];
          r_ovf   <= r_ovf_pend;
          r_valid <= 1'b1;
          r_last  <= r_capt;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd_out   = r_bcd;
  assign bcd_valid = r_valid;
  assign busy      = r_busy;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Self-checking bench for score_bcd_converter: table-driven conversions
// plus directed sequences for reset, mid-conversion changes and abort.
module tb_score_bcd_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] score_count;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int last_drv = 0;

  always #5 clk = ~clk;

  score_bcd_converter dut (
    .clk         (clk),
    .rst         (rst),
    .score_count (score_count),
    .bcd_out     (bcd_out),
    .bcd_valid   (bcd_valid),
    .busy        (busy),
    .overflow    (overflow)
  );

  typedef struct {
    int          value;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_bcd(input int v);
    int c;
    logic [15:0] r;
    c = (v > 9999) ? 9999 : v;
    r[15:12] = 4'(c / 1000 % 10);
    r[11:8]  = 4'(c / 100 % 10);
    r[7:4]   = 4'(c / 10 % 10);
    r[3:0]   = 4'(c % 10);
    return r;
  endfunction

  // Drive a new value at a falling edge, then wait for the result pulse.
  task automatic apply_check(input int v, input logic [15:0] exp_bcd,
                             input logic exp_ovf, input string name);
    int  cyc;
    bit  seen;
    bit  busy_ok;
    @(negedge clk);
    score_count = 14'(v);
    last_drv = v;
    cyc = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (cyc < 40 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (bcd_valid) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    if (!seen) begin
      chk({name, "_timeout"}, 32'(cyc), 32'd16);
      return;
    end
    chk({name, "_latency"}, 32'(cyc), 32'd16);
    chk({name, "_busy_during"}, 32'(busy_ok), 32'd1);
    chk({name, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    chk({name, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    @(posedge clk); #1;
    chk({name, "_pulse_one"}, 32'(bcd_valid), 32'd0);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses;
    int busy_seen;
    logic [15:0] first_bcd, second_bcd;
    int v;

    vecs[0]  = '{1234,  16'h1234, 1'b0};
    vecs[1]  = '{9999,  16'h9999, 1'b0};
    vecs[2]  = '{12000, 16'h9999, 1'b1};
    vecs[3]  = '{7,     16'h0007, 1'b0};
    vecs[4]  = '{10000, 16'h9999, 1'b1};
    vecs[5]  = '{16383, 16'h9999, 1'b1};
    vecs[6]  = '{9998,  16'h9998, 1'b0};
    vecs[7]  = '{305,   16'h0305, 1'b0};
    vecs[8]  = '{1,     16'h0001, 1'b0};
    vecs[9]  = '{8,     16'h0008, 1'b0};
    vecs[10] = '{4321,  16'h4321, 1'b0};
    vecs[11] = '{12000, 16'h9999, 1'b1};

    // Reset with input held at zero
    rst = 1'b1;
    score_count = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_valid", 32'(bcd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    busy_seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bcd_valid) pulses++;
      if (busy) busy_seen++;
    end
    chk("idle_pulses", 32'(pulses), 32'd0);
    chk("idle_busy", 32'(busy_seen), 32'd0);
    chk("idle_bcd", 32'(bcd_out), 32'h0);

    foreach (vecs[i]) apply_check(vecs[i].value, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));

    // Out-of-range value held: must not re-trigger
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bcd_valid) pulses++;
    end
    chk("hold_ovf_pulses", 32'(pulses), 32'd0);
    chk("hold_ovf_bcd", 32'(bcd_out), 32'h9999);
    chk("hold_ovf_flag", 32'(overflow), 32'd1);

    // Change during the 3rd CONVERT cycle: both values reported in order
    @(negedge clk);
    score_count = 14'd10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    score_count = 14'd57;
    last_drv = 57;
    pulses = 0;
    first_bcd = '0;
    second_bcd = '0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bcd_valid) begin
        pulses++;
        if (pulses == 1) first_bcd = bcd_out;
        if (pulses == 2) second_bcd = bcd_out;
      end
    end
    chk("midchg_pulses", 32'(pulses), 32'd2);
    chk("midchg_first", 32'(first_bcd), 32'h0010);
    chk("midchg_second", 32'(second_bcd), 32'h0057);
    chk("midchg_ovf", 32'(overflow), 32'd0);

    // Reset during the 7th CONVERT cycle aborts with no partial output
    @(negedge clk);
    score_count = 14'd500;
    last_drv = 500;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_bcd", 32'(bcd_out), 32'h0);
    chk("abort_valid", 32'(bcd_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    first_bcd = '0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bcd_valid) begin
        pulses++;
        first_bcd = bcd_out;
      end
    end
    chk("abort_reconv_pulses", 32'(pulses), 32'd1);
    chk("abort_reconv_bcd", 32'(first_bcd), 32'h0500);

    // Random sweep against the arithmetic digit model
    for (int n = 0; n < 1000; n++) begin
      v = int'($urandom_range(0, 16383));
      if (v == last_drv) v = (v + 1) % 16384;
      apply_check(v, model_bcd(v), (v > 9999), "sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_bcd_converter.md
Name: score_bcd_converter

Overview:
Reader side of the score path. It watches the binary score_count bus driven by the score accumulator and, whenever the value changes, converts it to packed BCD using an iterative shift-add-3 (double-dabble) engine. The BCD output feeds the seven-segment display drivers. It applies the same change-detection convention the accumulator uses on its input: a new value is acted on only when it differs from the last value handled.

Parameters:
MAX_SCORE, 9999, largest displayable score; binary width BIN_W = $clog2(MAX_SCORE) (14 at default), derived as a localparam
DIGITS, 4, number of BCD digits output; must satisfy 10^DIGITS > MAX_SCORE
CNT_W (localparam), $clog2(BIN_W+1), width of the iteration counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
score_count  input  BIN_W  binary score from the accumulator, may change on any cycle
bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) in [3:0]
bcd_valid  output  1  one-cycle pulse when bcd_out is updated
busy  output  1  high while a conversion is in progress (CONVERT or DONE)
overflow  output  1  high together with bcd_out when the converted sample exceeded MAX_SCORE

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, bcd_out=0, bcd_valid=0, busy=0, overflow=0, last_value=0, shift register and counter cleared. Reset has priority in every state and aborts a conversion in progress with no partial output.
- FSM states IDLE, CONVERT, DONE.
- IDLE:
  - If score_count != last_value: capture sample = min(score_count, MAX_SCORE), set ovf_pending = (score_count > MAX_SCORE), load the shift register with {BCD zeros, sample}, set counter=0, go to CONVERT.
  - Otherwise stay in IDLE.
- CONVERT:
  - Each cycle, add 3 to every BCD nibble that is >= 5, then shift the whole register left by 1. Both steps are combinational within one cycle.
  - counter increments each cycle. After BIN_W steps, go to DONE.
- DONE:
  - bcd_out <= BCD field; overflow <= ovf_pending; bcd_valid <= 1 for exactly one cycle; last_value <= score_count value captured at capture time (unclamped, so an out-of-range value is not re-triggered); go to IDLE.
- Latency: capture edge E0; shift edges E1..E(BIN_W); outputs update at edge E(BIN_W+1) (E15 at default); bcd_valid is high during the following cycle. The earliest next capture is edge E(BIN_W+2).
- busy = (state != IDLE), registered with the state.
- Input changes while busy are ignored. On return to IDLE the current score_count is compared with last_value. The final value is therefore always converted; intermediate values may be skipped.
- An unchanged input never produces bcd_valid. A change back to the original value before capture produces no conversion.
- bcd_out and overflow hold their value between updates.
- Width rules: BCD field is 4*DIGITS bits; shift register is 4*DIGITS+BIN_W bits; nibble adjust uses 4-bit unsigned compare/add with no carry out (the adjust guarantees a result <= 12).

Decomposition:
- Shared package whac_pkg: typedef bcd_digit_t (logic [3:0]); constant BCD_ADJ_THRESH=5; constant BCD_ADJ_ADD=3; function bcd_adjust(bcd_digit_t) returning the nibble +3 when it is >= 5.
- One sub-module, bcd_shift_step: combinational, parameterised by DIGITS and BIN_W; applies the per-digit adjust and the 1-bit left shift to the full shift register. The top level instantiates it once and holds the FSM, counter and registers.

Test Plan:
- Reset, score_count held at 0 for 50 cycles -> bcd_out=0x0000, bcd_valid never asserted, busy=0.
- score_count 0->1234 at edge E0 -> busy high from E0; bcd_out=0x1234 and overflow=0 at E15; bcd_valid high for exactly one cycle; busy low after.
- score_count=9999 -> bcd_out=0x9999, overflow=0. Then score_count=12000 -> bcd_out=0x9999, overflow=1. Held at 12000 -> no further bcd_valid.
- score_count=10, then 57 during the 3rd CONVERT cycle, held -> bcd_out=0x0010 with a valid pulse, then 0x0057 with a second pulse; exactly two pulses in total.
- score_count=500, rst pulsed during the 7th CONVERT cycle, then score_count held at 500 -> after reset bcd_out=0, valid=0, busy=0; then reconverted to 0x0500 with one valid pulse.
- Random sweep of 1000 values in 0..16383, each held until bcd_valid -> bcd_out equals the decimal digits of min(value, 9999); overflow equals (value > 9999).
